// File: rtl/ddr_port_arbiter_if.sv
// Signal bundle between the two cache clients, the arbiter and the DDR controller port.
// The arbiter takes the slave view; the surrounding clients plus DDR controller take the master view.
interface ddr_port_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
);
  logic              p0_rd_en;
  logic [ADDR_W-1:0] p0_rd_addr;
  logic              p0_rd_fin;
  logic [DATA_W-1:0] p0_rd_data;
  logic              p0_wr_en;
  logic [ADDR_W-1:0] p0_wr_addr;
  logic [DATA_W-1:0] p0_wr_data;
  logic              p0_wr_fin;

  logic              p1_rd_en;
  logic [ADDR_W-1:0] p1_rd_addr;
  logic              p1_rd_fin;
  logic [DATA_W-1:0] p1_rd_data;
  logic              p1_wr_en;
  logic [ADDR_W-1:0] p1_wr_addr;
  logic [DATA_W-1:0] p1_wr_data;
  logic              p1_wr_fin;

  logic              ddr_rd_en;
  logic [ADDR_W-1:0] ddr_rd_addr;
  logic              ddr_rd_fin;
  logic [DATA_W-1:0] ddr_rd_data;
  logic              ddr_wr_en;
  logic [ADDR_W-1:0] ddr_wr_addr;
  logic [DATA_W-1:0] ddr_wr_data;
  logic              ddr_wr_fin;

  modport slave (
    input  p0_rd_en, p0_rd_addr, p0_wr_en, p0_wr_addr, p0_wr_data,
    input  p1_rd_en, p1_rd_addr, p1_wr_en, p1_wr_addr, p1_wr_data,
    output p0_rd_fin, p0_rd_data, p0_wr_fin,
    output p1_rd_fin, p1_rd_data, p1_wr_fin,
    output ddr_rd_en, ddr_rd_addr, ddr_wr_en, ddr_wr_addr, ddr_wr_data,
    input  ddr_rd_fin, ddr_rd_data, ddr_wr_fin
  );

  modport master (
    output p0_rd_en, p0_rd_addr, p0_wr_en, p0_wr_addr, p0_wr_data,
    output p1_rd_en, p1_rd_addr, p1_wr_en, p1_wr_addr, p1_wr_data,
    input  p0_rd_fin, p0_rd_data, p0_wr_fin,
    input  p1_rd_fin, p1_rd_data, p1_wr_fin,
    input  ddr_rd_en, ddr_rd_addr, ddr_wr_en, ddr_wr_addr, ddr_wr_data,
    output ddr_rd_fin, ddr_rd_data, ddr_wr_fin
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Two-client round-robin arbiter for the single DDR port: one-deep request slots,
// one outstanding DDR transaction, completions routed back to the owning client.
module ddr_port_arbiter #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rstn,
  ddr_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              overflow
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;
  localparam logic [1:0] ST_WAIT_WR = 2'd3;

  // Slot index = {port, is_write}: S0 p0 rd, S1 p0 wr, S2 p1 rd, S3 p1 wr.
  logic [1:0]        state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              overflow_q, overflow_d;
  logic [3:0]        slot_vld_q, slot_vld_d;
  logic [ADDR_W-1:0] slot_addr_q [4];
  logic [ADDR_W-1:0] slot_addr_d [4];
  logic [DATA_W-1:0] slot_data_q [2];
  logic [DATA_W-1:0] slot_data_d [2];
  logic              ddr_rd_en_q, ddr_rd_en_d;
  logic              ddr_wr_en_q, ddr_wr_en_d;
  logic [ADDR_W-1:0] ddr_rd_addr_q, ddr_rd_addr_d;
  logic [ADDR_W-1:0] ddr_wr_addr_q, ddr_wr_addr_d;
  logic [DATA_W-1:0] ddr_wr_data_q, ddr_wr_data_d;
  logic [1:0]        rd_fin_q, rd_fin_d;
  logic [1:0]        wr_fin_q, wr_fin_d;
  logic [DATA_W-1:0] rd_data_q [2];
  logic [DATA_W-1:0] rd_data_d [2];

  logic [3:0]        req_en;
  logic [ADDR_W-1:0] req_addr [4];
  logic              found;
  logic [1:0]        gnt_idx;
  logic [1:0]        cand;

  assign req_en      = {bus.p1_wr_en, bus.p1_rd_en, bus.p0_wr_en, bus.p0_rd_en};
  assign req_addr[0] = bus.p0_rd_addr;
  assign req_addr[1] = bus.p0_wr_addr;
  assign req_addr[2] = bus.p1_rd_addr;
  assign req_addr[3] = bus.p1_wr_addr;

  // First valid slot starting at the round-robin pointer.
  always_comb begin
    found   = 1'b0;
    gnt_idx = rr_q;
    cand    = rr_q;
    for (int i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (!found && slot_vld_q[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    rr_d          = rr_q;
    gnt_d         = gnt_q;
    overflow_d    = overflow_q;
    slot_vld_d    = slot_vld_q;
    slot_addr_d   = slot_addr_q;
    slot_data_d   = slot_data_q;
    ddr_rd_en_d   = 1'b0;
    ddr_wr_en_d   = 1'b0;
    ddr_rd_addr_d = ddr_rd_addr_q;
    ddr_wr_addr_d = ddr_wr_addr_q;
    ddr_wr_data_d = ddr_wr_data_q;
    rd_fin_d      = '0;
    wr_fin_d      = '0;
    rd_data_d     = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_ISSUE;
          gnt_d   = gnt_idx;
          rr_d    = gnt_idx + 2'd1;
          if (gnt_idx[0]) begin
            ddr_wr_en_d   = 1'b1;
            ddr_wr_addr_d = slot_addr_q[gnt_idx];
            ddr_wr_data_d = slot_data_q[gnt_idx[1]];
          end else begin
            ddr_rd_en_d   = 1'b1;
            ddr_rd_addr_d = slot_addr_q[gnt_idx];
          end
        end
      end
      ST_ISSUE: state_d = gnt_q[0] ? ST_WAIT_WR : ST_WAIT_RD;
      ST_WAIT_RD: begin
        if (bus.ddr_rd_fin) begin
          state_d               = ST_IDLE;
          slot_vld_d[gnt_q]     = 1'b0;
          rd_fin_d[gnt_q[1]]    = 1'b1;
          rd_data_d[gnt_q[1]]   = bus.ddr_rd_data;
        end
      end
      ST_WAIT_WR: begin
        if (bus.ddr_wr_fin) begin
          state_d            = ST_IDLE;
          slot_vld_d[gnt_q]  = 1'b0;
          wr_fin_d[gnt_q[1]] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Acceptance looks at the slot as it stood at this edge, so a request racing its own fin is dropped.
    for (int i = 0; i < 4; i++) begin
      if (req_en[i]) begin
        if (slot_vld_q[i]) begin
          overflow_d = 1'b1;
        end else begin
          slot_vld_d[i]  = 1'b1;
          slot_addr_d[i] = req_addr[i];
        end
      end
    end
    if (req_en[1] && !slot_vld_q[1]) slot_data_d[0] = bus.p0_wr_data;
    if (req_en[3] && !slot_vld_q[3]) slot_data_d[1] = bus.p1_wr_data;
  end

  // NOTE: state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      rr_q          <= 2'd0;
      gnt_q         <= 2'd0;
      overflow_q    <= 1'b0;
      slot_vld_q    <= '0;
      ddr_rd_en_q   <= 1'b0;
      ddr_wr_en_q   <= 1'b0;
      ddr_rd_addr_q <= '0;
      ddr_wr_addr_q <= '0;
      ddr_wr_data_q <= '0;
      rd_fin_q      <= '0;
      wr_fin_q      <= '0;
      rd_data_q[0]  <= '0;
      rd_data_q[1]  <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      gnt_q         <= gnt_d;
      overflow_q    <= overflow_d;
      slot_vld_q    <= slot_vld_d;
      ddr_rd_en_q   <= ddr_rd_en_d;
      ddr_wr_en_q   <= ddr_wr_en_d;
      ddr_rd_addr_q <= ddr_rd_addr_d;
      ddr_wr_addr_q <= ddr_wr_addr_d;
      ddr_wr_data_q <= ddr_wr_data_d;
      rd_fin_q      <= rd_fin_d;
      wr_fin_q      <= wr_fin_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // NOTE: slot payloads are not reset; the valid bits alone decide whether they are ever read.
  always_ff @(posedge clk) begin
    slot_addr_q <= slot_addr_d;
    slot_data_q <= slot_data_d;
  end

  assign bus.ddr_rd_en   = ddr_rd_en_q;
  assign bus.ddr_wr_en   = ddr_wr_en_q;
  assign bus.ddr_rd_addr = ddr_rd_addr_q;
  assign bus.ddr_wr_addr = ddr_wr_addr_q;
  assign bus.ddr_wr_data = ddr_wr_data_q;
  assign bus.p0_rd_fin   = rd_fin_q[0];
  assign bus.p1_rd_fin   = rd_fin_q[1];
  assign bus.p0_wr_fin   = wr_fin_q[0];
  assign bus.p1_wr_fin   = wr_fin_q[1];
  assign bus.p0_rd_data  = rd_data_q[0];
  assign bus.p1_rd_data  = rd_data_q[1];
  assign busy            = (state_q != ST_IDLE);
  assign overflow        = overflow_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed scenarios plus a randomized run against a slot/round-robin reference model.
module tb_ddr_port_arbiter;
  localparam int AW = 27;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rstn;
  logic busy;
  logic overflow;
  int   total = 0;
  int   bad   = 0;

  ddr_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ddr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.p0_rd_en = 1'b0; bus.p0_rd_addr = '0;
    bus.p0_wr_en = 1'b0; bus.p0_wr_addr = '0; bus.p0_wr_data = '0;
    bus.p1_rd_en = 1'b0; bus.p1_rd_addr = '0;
    bus.p1_wr_en = 1'b0; bus.p1_wr_addr = '0; bus.p1_wr_data = '0;
    bus.ddr_rd_fin = 1'b0; bus.ddr_rd_data = '0; bus.ddr_wr_fin = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (3) tick();
    rstn = 1'b1;
  endtask

  function automatic logic [445:0] outs();
    return {bus.ddr_rd_en, bus.ddr_wr_en, bus.p0_rd_fin, bus.p0_wr_fin, bus.p1_rd_fin,
            bus.p1_wr_fin, busy, overflow, bus.ddr_rd_addr, bus.ddr_wr_addr, bus.ddr_wr_data,
            bus.p0_rd_data, bus.p1_rd_data};
  endfunction

  function automatic logic [3:0] fins();
    return {bus.p1_wr_fin, bus.p1_rd_fin, bus.p0_wr_fin, bus.p0_rd_fin};
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    clear_inputs();
    tick();
    bus.p0_rd_en = 1'b1; bus.p0_rd_addr = 27'h0000123;
    tick();
    clear_inputs();
    tick();
    rstn = 1'b1;
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs()); end
    tick(); tick();
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL reset_no_capture: got %h want 0", outs()); end
  endtask

  task automatic test_basic_read();
    logic [DW-1:0] line;
    line = 128'hDEADBEEF;
    do_reset();
    bus.p0_rd_en = 1'b1; bus.p0_rd_addr = 27'h0000100;
    tick();
    bus.p0_rd_en = 1'b0;
    total++;
    if ({bus.ddr_rd_en, busy} !== 2'b00) begin
      bad++; $display("FAIL basic_cycle1: ddr_rd_en,busy=%b want 00", {bus.ddr_rd_en, busy});
    end
    tick();
    total++;
    if (bus.ddr_rd_en !== 1'b1 || bus.ddr_rd_addr !== 27'h0000100 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_issue: en=%b addr=%h busy=%b want 1 0000100 1", bus.ddr_rd_en, bus.ddr_rd_addr, busy);
    end
    repeat (5) tick();
    bus.ddr_rd_fin = 1'b1; bus.ddr_rd_data = line;
    tick();
    bus.ddr_rd_fin = 1'b0; bus.ddr_rd_data = '0;
    total++;
    if (fins() !== 4'b0001 || bus.p0_rd_data !== line || busy !== 1'b0) begin
      bad++; $display("FAIL basic_fin: fins=%b data=%h busy=%b want 0001 %h 0", fins(), bus.p0_rd_data, busy, line);
    end
    total++;
    if (bus.p1_rd_data !== '0 || bus.ddr_wr_en !== 1'b0 || bus.ddr_wr_addr !== '0) begin
      bad++; $display("FAIL basic_p1_quiet: p1_rd_data=%h wr_en=%b want 0", bus.p1_rd_data, bus.ddr_wr_en);
    end
    bus.p0_rd_en = 1'b1; bus.p0_rd_addr = 27'h0000140;
    tick();
    bus.p0_rd_en = 1'b0;
    total++;
    if (fins() !== 4'b0000 || bus.p0_rd_data !== line) begin
      bad++; $display("FAIL basic_hold: fins=%b data=%h want 0000 %h", fins(), bus.p0_rd_data, line);
    end
    tick();
    total++;
    if (bus.ddr_rd_en !== 1'b1 || bus.ddr_rd_addr !== 27'h0000140 || overflow !== 1'b0) begin
      bad++; $display("FAIL basic_rerequest: en=%b addr=%h ovf=%b want 1 0000140 0", bus.ddr_rd_en, bus.ddr_rd_addr, overflow);
    end
    tick();
    bus.ddr_rd_fin = 1'b1; bus.ddr_rd_data = ~line;
    tick();
    bus.ddr_rd_fin = 1'b0;
    total++;
    if (fins() !== 4'b0001 || bus.p0_rd_data !== ~line || overflow !== 1'b0) begin
      bad++; $display("FAIL basic_second_fin: fins=%b data=%h ovf=%b", fins(), bus.p0_rd_data, overflow);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.p0_rd_en = 1'b1; bus.p0_rd_addr = 27'h0000200;
    bus.p1_rd_en = 1'b1; bus.p1_rd_addr = 27'h0000300;
    tick(); clear_inputs();
    tick();
    total++;
    if (bus.ddr_rd_en !== 1'b1 || bus.ddr_rd_addr !== 27'h0000200) begin
      bad++; $display("FAIL rr_first_p0: en=%b addr=%h want 1 0000200", bus.ddr_rd_en, bus.ddr_rd_addr);
    end
    tick(); bus.ddr_rd_fin = 1'b1; bus.ddr_rd_data = 128'h11;
    tick(); bus.ddr_rd_fin = 1'b0;
    total++;
    if (fins() !== 4'b0001) begin bad++; $display("FAIL rr_fin_p0: fins=%b want 0001", fins()); end
    tick();
    total++;
    if (bus.ddr_rd_en !== 1'b1 || bus.ddr_rd_addr !== 27'h0000300) begin
      bad++; $display("FAIL rr_then_p1: en=%b addr=%h want 1 0000300", bus.ddr_rd_en, bus.ddr_rd_addr);
    end
    tick(); bus.ddr_rd_fin = 1'b1; bus.ddr_rd_data = 128'h22;
    tick(); bus.ddr_rd_fin = 1'b0;
    total++;
    if (fins() !== 4'b0100 || bus.p1_rd_data !== 128'h22) begin
      bad++; $display("FAIL rr_fin_p1: fins=%b data=%h want 0100 22", fins(), bus.p1_rd_data);
    end
    // Pointer now at S3, so the search wraps to S0 first.
    bus.p0_rd_en = 1'b1; bus.p0_rd_addr = 27'h0000210;
    bus.p1_rd_en = 1'b1; bus.p1_rd_addr = 27'h0000310;
    tick(); clear_inputs();
    tick();
    total++;
    if (bus.ddr_rd_addr !== 27'h0000210 || bus.ddr_rd_en !== 1'b1) begin
      bad++; $display("FAIL rr_wrap_p0: en=%b addr=%h want 1 0000210", bus.ddr_rd_en, bus.ddr_rd_addr);
    end
    tick(); bus.ddr_rd_fin = 1'b1;
    tick(); bus.ddr_rd_fin = 1'b0;
    tick();
    total++;
    if (bus.ddr_rd_addr !== 27'h0000310 || bus.ddr_rd_en !== 1'b1) begin
      bad++; $display("FAIL rr_wrap_p1: en=%b addr=%h want 1 0000310", bus.ddr_rd_en, bus.ddr_rd_addr);
    end
    tick(); bus.ddr_rd_fin = 1'b1;
    tick(); bus.ddr_rd_fin = 1'b0;
    // A p0 write moves the pointer to S2, so p1 read beats p0 read next.
    bus.p0_wr_en = 1'b1; bus.p0_wr_addr = 27'h0000220; bus.p0_wr_data = 128'h33;
    tick(); clear_inputs();
    tick();
    total++;
    if (bus.ddr_wr_en !== 1'b1 || bus.ddr_wr_addr !== 27'h0000220 || bus.ddr_wr_data !== 128'h33) begin
      bad++; $display("FAIL rr_p0_wr: en=%b addr=%h data=%h", bus.ddr_wr_en, bus.ddr_wr_addr, bus.ddr_wr_data);
    end
    bus.p0_rd_en = 1'b1; bus.p0_rd_addr = 27'h0000230;
    bus.p1_rd_en = 1'b1; bus.p1_rd_addr = 27'h0000330;
    tick(); clear_inputs(); bus.ddr_wr_fin = 1'b1;
    tick(); bus.ddr_wr_fin = 1'b0;
    total++;
    if (fins() !== 4'b0010) begin bad++; $display("FAIL rr_wr_fin: fins=%b want 0010", fins()); end
    tick();
    total++;
    if (bus.ddr_rd_en !== 1'b1 || bus.ddr_rd_addr !== 27'h0000330) begin
      bad++; $display("FAIL rr_p1_before_p0: en=%b addr=%h want 1 0000330", bus.ddr_rd_en, bus.ddr_rd_addr);
    end
    tick(); bus.ddr_rd_fin = 1'b1;
    tick(); bus.ddr_rd_fin = 1'b0;
    tick();
    total++;
    if (bus.ddr_rd_en !== 1'b1 || bus.ddr_rd_addr !== 27'h0000230) begin
      bad++; $display("FAIL rr_p0_last: en=%b addr=%h want 1 0000230", bus.ddr_rd_en, bus.ddr_rd_addr);
    end
    tick(); bus.ddr_rd_fin = 1'b1;
    tick(); bus.ddr_rd_fin = 1'b0;
  endtask

  task automatic test_wr_after_rd();
    logic [DW-1:0] wline;
    wline = {16{8'hA5}};
    do_reset();
    bus.p1_rd_en = 1'b1; bus.p1_rd_addr = 27'h0400010;
    tick(); clear_inputs();
    tick();
    total++;
    if (bus.ddr_rd_en !== 1'b1 || bus.ddr_rd_addr !== 27'h0400010) begin
      bad++; $display("FAIL wmiss_rd_issue: en=%b addr=%h want 1 0400010", bus.ddr_rd_en, bus.ddr_rd_addr);
    end
    tick(); tick();
    bus.ddr_rd_fin = 1'b1; bus.ddr_rd_data = 128'h5555;
    tick(); bus.ddr_rd_fin = 1'b0;
    total++;
    if (fins() !== 4'b0100 || bus.p1_rd_data !== 128'h5555 || bus.p0_rd_data !== '0) begin
      bad++; $display("FAIL wmiss_rd_fin: fins=%b p1=%h p0=%h", fins(), bus.p1_rd_data, bus.p0_rd_data);
    end
    bus.p1_wr_en = 1'b1; bus.p1_wr_addr = 27'h0400010; bus.p1_wr_data = wline;
    tick(); clear_inputs();
    tick();
    total++;
    if (bus.ddr_wr_en !== 1'b1 || bus.ddr_wr_addr !== 27'h0400010 || bus.ddr_wr_data !== wline || bus.ddr_rd_en !== 1'b0) begin
      bad++; $display("FAIL wmiss_wr_issue: en=%b addr=%h data=%h", bus.ddr_wr_en, bus.ddr_wr_addr, bus.ddr_wr_data);
    end
    tick(); bus.ddr_wr_fin = 1'b1;
    tick(); bus.ddr_wr_fin = 1'b0;
    total++;
    if (fins() !== 4'b1000 || overflow !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL wmiss_wr_fin: fins=%b ovf=%b busy=%b want 1000 0 0", fins(), overflow, busy);
    end
  endtask

  task automatic test_overflow();
    int n_en, n_fin;
    do_reset();
    bus.p0_rd_en = 1'b1; bus.p0_rd_addr = 27'h0000500;
    tick();
    bus.p0_rd_addr = 27'h0000600;
    tick();
    total++;
    if (overflow !== 1'b1 || bus.ddr_rd_en !== 1'b1 || bus.ddr_rd_addr !== 27'h0000500) begin
      bad++; $display("FAIL ovf_set: ovf=%b en=%b addr=%h want 1 1 0000500", overflow, bus.ddr_rd_en, bus.ddr_rd_addr);
    end
    bus.p0_rd_addr = 27'h0000700;
    tick(); clear_inputs();
    bus.ddr_rd_fin = 1'b1; bus.ddr_rd_data = 128'h77;
    tick(); bus.ddr_rd_fin = 1'b0;
    total++;
    if (fins() !== 4'b0001 || bus.p0_rd_data !== 128'h77) begin
      bad++; $display("FAIL ovf_fin: fins=%b data=%h want 0001 77", fins(), bus.p0_rd_data);
    end
    n_en = 0; n_fin = 0;
    repeat (8) begin
      tick();
      if (bus.ddr_rd_en === 1'b1) n_en++;
      if (bus.p0_rd_fin === 1'b1) n_fin++;
    end
    total++;
    if (n_en != 0 || n_fin != 0 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_dropped: extra_en=%0d extra_fin=%0d ovf=%b want 0 0 1", n_en, n_fin, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.p0_rd_en = 1'b1; bus.p0_rd_addr = 27'h0000800;
    tick(); clear_inputs();
    tick(); tick();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL rstmid_outputs: got %h want 0", outs()); end
    bus.ddr_rd_fin = 1'b1; bus.ddr_rd_data = 128'h99;
    tick(); bus.ddr_rd_fin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (outs() !== '0) begin bad++; $display("FAIL rstmid_late_fin%0d: got %h want 0", i, outs()); end
      tick();
    end
  endtask

  task automatic test_spurious();
    do_reset();
    bus.ddr_wr_fin = 1'b1;
    tick(); bus.ddr_wr_fin = 1'b0;
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL spur_idle_wr: got %h want 0", outs()); end
    bus.ddr_rd_fin = 1'b1; bus.ddr_rd_data = 128'hAB;
    tick(); bus.ddr_rd_fin = 1'b0;
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL spur_idle_rd: got %h want 0", outs()); end
    bus.p1_rd_en = 1'b1; bus.p1_rd_addr = 27'h0000900;
    tick(); clear_inputs();
    tick(); tick();
    bus.ddr_wr_fin = 1'b1;
    tick(); bus.ddr_wr_fin = 1'b0;
    total++;
    if (fins() !== 4'b0000 || busy !== 1'b1) begin
      bad++; $display("FAIL spur_wait_rd: fins=%b busy=%b want 0000 1", fins(), busy);
    end
    bus.ddr_rd_fin = 1'b1; bus.ddr_rd_data = 128'hCD;
    tick(); bus.ddr_rd_fin = 1'b0;
    total++;
    if (fins() !== 4'b0100 || bus.p1_rd_data !== 128'hCD || busy !== 1'b0) begin
      bad++; $display("FAIL spur_real_fin: fins=%b data=%h busy=%b want 0100 cd 0", fins(), bus.p1_rd_data, busy);
    end
  endtask

  task automatic test_random();
    bit            pend [4];
    bit            old_pend [4];
    logic [AW-1:0] paddr [4];
    logic [DW-1:0] pdata [4];
    logic [AW-1:0] req_a [4];
    logic [DW-1:0] req_d [4];
    logic [DW-1:0] held [2];
    logic [DW-1:0] rsp;
    logic [3:0]    exp_fin, drv_en;
    logic [1:0]    rr, s;
    int            cur, gcyc, fin_at, en_slot;
    bit            ovf, rd_fin_drv, wr_fin_drv, exp_rd, exp_wr;
    do_reset();
    for (int k = 0; k < 4; k++) pend[k] = 1'b0;
    held[0] = '0; held[1] = '0;
    rr = 2'd0; cur = -1; gcyc = 0; fin_at = 0; en_slot = -1; exp_fin = '0; ovf = 1'b0;
    for (int c = 0; c < 600; c++) begin
      exp_rd = (en_slot >= 0) && (en_slot % 2 == 0);
      exp_wr = (en_slot >= 0) && (en_slot % 2 == 1);
      total++;
      if (bus.ddr_rd_en !== exp_rd || bus.ddr_wr_en !== exp_wr) begin
        bad++; $display("FAIL rand_cmd c=%0d: rd_en,wr_en=%b%b want %b%b", c, bus.ddr_rd_en, bus.ddr_wr_en, exp_rd, exp_wr);
      end
      if (exp_rd) begin
        total++;
        if (bus.ddr_rd_addr !== paddr[en_slot]) begin
          bad++; $display("FAIL rand_rd_addr c=%0d: got %h want %h", c, bus.ddr_rd_addr, paddr[en_slot]);
        end
      end
      if (exp_wr) begin
        total++;
        if (bus.ddr_wr_addr !== paddr[en_slot] || bus.ddr_wr_data !== pdata[en_slot]) begin
          bad++; $display("FAIL rand_wr c=%0d: addr=%h data=%h want %h %h", c, bus.ddr_wr_addr, bus.ddr_wr_data, paddr[en_slot], pdata[en_slot]);
        end
      end
      total++;
      if (fins() !== exp_fin || bus.p0_rd_data !== held[0] || bus.p1_rd_data !== held[1]) begin
        bad++; $display("FAIL rand_fin c=%0d: fins=%b want %b p0=%h p1=%h", c, fins(), exp_fin, bus.p0_rd_data, bus.p1_rd_data);
      end
      total++;
      if (busy !== (cur >= 0) || overflow !== ovf) begin
        bad++; $display("FAIL rand_status c=%0d: busy=%b ovf=%b want %b %b", c, busy, overflow, cur >= 0, ovf);
      end

      drv_en = '0;
      for (int k = 0; k < 4; k++) begin
        if (c < 540 && $urandom_range(0, 9) == 0) drv_en[k] = 1'b1;
        req_a[k] = AW'($urandom);
        req_d[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.p0_rd_en = drv_en[0]; bus.p0_rd_addr = req_a[0];
      bus.p0_wr_en = drv_en[1]; bus.p0_wr_addr = req_a[1]; bus.p0_wr_data = req_d[1];
      bus.p1_rd_en = drv_en[2]; bus.p1_rd_addr = req_a[2];
      bus.p1_wr_en = drv_en[3]; bus.p1_wr_addr = req_a[3]; bus.p1_wr_data = req_d[3];
      rd_fin_drv = 1'b0; wr_fin_drv = 1'b0;
      if (cur >= 0 && c == fin_at) begin
        if (cur % 2 == 0) rd_fin_drv = 1'b1; else wr_fin_drv = 1'b1;
      end else if ($urandom_range(0, 11) == 0) begin
        if (cur < 0) begin
          if ($urandom_range(0, 1) == 1) rd_fin_drv = 1'b1; else wr_fin_drv = 1'b1;
        end else if (cur % 2 == 0) wr_fin_drv = 1'b1;
        else rd_fin_drv = 1'b1;
      end
      rsp = {$urandom, $urandom, $urandom, $urandom};
      bus.ddr_rd_fin = rd_fin_drv; bus.ddr_rd_data = rsp; bus.ddr_wr_fin = wr_fin_drv;

      old_pend = pend;
      en_slot = -1;
      exp_fin = '0;
      if (cur >= 0 && c >= gcyc + 2 && ((cur % 2 == 0 && rd_fin_drv) || (cur % 2 == 1 && wr_fin_drv))) begin
        exp_fin[cur] = 1'b1;
        if (cur % 2 == 0) held[cur / 2] = rsp;
        pend[cur] = 1'b0;
        cur = -1;
      end else if (cur < 0) begin
        for (int k = 0; k < 4; k++) begin
          s = rr + 2'(k);
          if (cur < 0 && old_pend[s]) cur = int'(s);
        end
        if (cur >= 0) begin
          gcyc = c; en_slot = cur; rr = 2'(cur + 1);
          fin_at = c + 1 + $urandom_range(1, 4);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (drv_en[k]) begin
          if (old_pend[k]) ovf = 1'b1;
          else begin pend[k] = 1'b1; paddr[k] = req_a[k]; pdata[k] = req_d[k]; end
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_round_robin();
    test_wr_after_rd();
    test_overflow();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
